// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the 4-channel round-robin arbitration stage.
package mux_arb_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned SEL_WIDTH = 2;

    typedef logic [SEL_WIDTH-1:0] sel_t;

    // IDLE: free arbitration between packets; LOCK: a packet owns the stage.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage : mux_arb_pkg

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker.
// The search starts one past ptr, so the channel at ptr has lowest priority.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  sel_t              ptr,
    output sel_t              grant_idx,
    output logic              any_req
);

    sel_t              start;
    sel_t              offset;
    logic              found;
    logic [NUM_CH-1:0] rot;

    // Rotate so that bit 0 of rot is the channel just after ptr.
    always_comb begin
        start = sel_t'(ptr + sel_t'(1));
        rot   = '0;
        for (int j = 0; j < int'(NUM_CH); j++) begin
            rot[j] = req[sel_t'(start + sel_t'(j))];
        end
    end

    // Priority-encode the rotated vector (lowest set bit wins).
    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int j = 0; j < int'(NUM_CH); j++) begin
            if (!found && rot[j]) begin
                offset = sel_t'(j);
                found  = 1'b1;
            end
        end
    end

    // Un-rotate the winning offset back to a channel index.
    always_comb begin
        grant_idx = sel_t'(start + offset);
        any_req   = |req;
    end

endmodule : rr_pick4

// File: rtl/mux_4to1_64bit_rr_arb.sv
// Round-robin, packet-locking arbiter in front of the 4:1 64-bit data mux.
// Holds the grant for whole packets and registers the selected beat into a
// single-entry valid/ready output stage.
module mux_4to1_64bit_rr_arb
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned SEL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH-1:0]    in_last,
    output logic [NUM_CH-1:0]    in_ready,
    input  logic [WIDTH-1:0]     data0,
    input  logic [WIDTH-1:0]     data1,
    input  logic [WIDTH-1:0]     data2,
    input  logic [WIDTH-1:0]     data3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [SEL_WIDTH-1:0] out_sel
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    sel_t             rr_ptr_q;
    sel_t             rr_ptr_d;
    sel_t             lock_ch_q;
    sel_t             lock_ch_d;

    sel_t             pick_idx_c;
    logic             any_req_c;
    sel_t             cur_c;
    logic             load_c;
    logic [WIDTH-1:0] sel_data_c;

    rr_pick4 u_pick (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant_idx (pick_idx_c),
        .any_req   (any_req_c)
    );

    // Current owner: the locked channel mid-packet, otherwise the rr pick.
    always_comb begin
        cur_c = pick_idx_c;
        if (state_q == LOCK) begin
            cur_c = lock_ch_q;
        end
    end

    // Load when the output slot is free or draining and the owner presents a beat.
    always_comb begin
        load_c = (!out_valid || out_ready) && in_valid[cur_c] &&
                 ((state_q == LOCK) || any_req_c);
    end

    // One-hot ready to the owning channel only.
    always_comb begin
        in_ready = '0;
        if (load_c) begin
            in_ready[cur_c] = 1'b1;
        end
    end

    // Data select for the owning channel.
    always_comb begin
        sel_data_c = data0;
        case (cur_c)
            2'd0:    sel_data_c = data0;
            2'd1:    sel_data_c = data1;
            2'd2:    sel_data_c = data2;
            2'd3:    sel_data_c = data3;
            default: sel_data_c = data0;
        endcase
    end

    // Next-state logic; the pointer moves only when a packet completes.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            IDLE: begin
                if (load_c) begin
                    if (in_last[cur_c]) begin
                        rr_ptr_d = cur_c;
                    end else begin
                        state_d   = LOCK;
                        lock_ch_d = cur_c;
                    end
                end
            end
            LOCK: begin
                if (load_c && in_last[lock_ch_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = lock_ch_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbitration state registers; rr_ptr=3 gives channel 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= sel_t'(3);
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // Single-entry output stage; a load replaces a beat being accepted with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (load_c) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_c;
            out_last  <= in_last[cur_c];
            out_sel   <= SEL_WIDTH'(cur_c);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : mux_4to1_64bit_rr_arb

// File: tb/tb_mux_4to1_64bit_rr_arb.sv
// Directed, table-driven bench for the round-robin packet arbiter.
module tb_mux_4to1_64bit_rr_arb;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid;
    logic [3:0]       in_last;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [WIDTH-1:0] data3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [1:0]       out_sel;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       ready;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_sel;
        logic       exp_last;
    } vec_t;

    vec_t vecs[$];

    mux_4to1_64bit_rr_arb #(.WIDTH(WIDTH), .SEL_WIDTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] chan_data(input logic [1:0] ch);
        case (ch)
            2'd0:    return 64'h0123_4567_89AB_CDEF;
            2'd1:    return 64'h0000_0000_DEAD_BEEF;
            2'd2:    return 64'hFEDC_BA98_7654_3210;
            default: return 64'h5A5A_A5A5_0F0F_F0F0;
        endcase
    endfunction

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic r,
                       input logic [3:0] er, input logic eov, input logic [1:0] es,
                       input logic el);
        vec_t t;
        t.valid = v; t.last = l; t.ready = r;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_sel = es; t.exp_last = el;
        vecs.push_back(t);
    endtask

    // Drive one cycle, check combinational ready before the edge and registered outputs after it.
    task automatic apply(input vec_t t, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        in_valid  = t.valid;
        in_last   = t.last;
        out_ready = t.ready;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'(t.exp_rdy));
        @(posedge clk);
        #1;
        check({tag, " out_valid"}, 64'(out_valid), 64'(t.exp_ov));
        check({tag, " out_sel"}, 64'(out_sel), 64'(t.exp_sel));
        if (t.exp_ov) begin
            check({tag, " out_data"}, out_data, chan_data(t.exp_sel));
            check({tag, " out_last"}, 64'(out_last), 64'(t.exp_last));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        data0     = chan_data(2'd0);
        data1     = chan_data(2'd1);
        data2     = chan_data(2'd2);
        data3     = chan_data(2'd3);
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;

        // 1: all channels valid, single-beat packets -> 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            add(4'b1111, 4'b1111, 1'b1, 4'b0001 << (i % 4), 1'b1, 2'(i % 4), 1'b1);
        end
        // 2: move pointer to 1, then a 3-beat ch2 packet while ch0/ch1 wait, then ch0
        add(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1);
        add(4'b0111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b0111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(4'b0111, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1);
        add(4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1);
        // 3: ch1 DEAD_BEEF held under 5 cycles of back-pressure, then ch0 replaces it
        add(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            add(4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1);
        end
        add(4'b0011, 4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1);
        // 4: ch3 locked, drops valid for 2 cycles while ch0 requests; ch3 completes first
        add(4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0);
        add(4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0);
        add(4'b1001, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1);
        add(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1);
        // 6: only ch3 valid, single beats: accepted every cycle
        for (int i = 0; i < 4; i++) begin
            add(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1);
        end
        // 5 (setup): open a ch1 packet and hold its first beat
        add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_sel", 64'(out_sel), 64'd0);
        check("reset out_data", out_data, 64'd0);
        check("reset out_last", 64'(out_last), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // 5: reset mid-packet with a held beat; lock and beat are dropped
        rst       = 1'b1;
        in_valid  = 4'b0011;
        in_last   = 4'b0000;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst out_sel", 64'(out_sel), 64'd0);
        check("midrst out_data", out_data, 64'd0);
        rst       = 1'b0;
        in_last   = 4'b0011;
        out_ready = 1'b1;
        #1;
        check("postrst in_ready", 64'(in_ready), 64'b0001);
        @(posedge clk);
        #1;
        check("postrst out_valid", 64'(out_valid), 64'd1);
        check("postrst out_sel", 64'(out_sel), 64'd0);
        check("postrst out_data", out_data, chan_data(2'd0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux_4to1_64bit_rr_arb
